// File: rtl/s2qed_fetch_pkg.sv
// Shared types and constants for the S2QED dual-core instruction-fetch bridge.
package s2qed_fetch_pkg;

    localparam int unsigned OBI_ADDR_WIDTH = 32;

    typedef enum logic {
        CORE1 = 1'b0,
        CORE2 = 1'b1
    } core_sel_e;

    function automatic core_sel_e other_core(input core_sel_e c);
        return (c == CORE1) ? CORE2 : CORE1;
    endfunction

endpackage

// File: rtl/s2qed_route_fifo.sv
// In-order FIFO of core identifiers, one entry per granted-but-unanswered fetch.
module s2qed_route_fifo
    import s2qed_fetch_pkg::*;
#(
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push,
    input  core_sel_e       push_sel,
    input  logic            pop,
    output core_sel_e       head,
    output logic            full,
    output logic            empty,
    output logic [CntW-1:0] count
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    core_sel_e             entries_q [Depth];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = entries_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                entries_q[i] <= CORE1;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                entries_q[wr_ptr_q] <= push_sel;
            end
        end
    end

endmodule

// File: rtl/s2qed_instr_fetch_bridge.sv
// Merges two cores' OBI instruction channels onto one memory port with locked
// round-robin arbitration and in-order response routing.
module s2qed_instr_fetch_bridge
    import s2qed_fetch_pkg::*;
#(
    parameter int unsigned INSTR_RDATA_WIDTH = 32,
    parameter int unsigned MAX_OUTSTANDING   = 2,
    localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         instr_req_1_i,
    input  logic [OBI_ADDR_WIDTH-1:0]    instr_addr_1_i,
    output logic                         instr_gnt_1_o,
    output logic                         instr_rvalid_1_o,
    output logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_1_o,
    input  logic                         instr_req_2_i,
    input  logic [OBI_ADDR_WIDTH-1:0]    instr_addr_2_i,
    output logic                         instr_gnt_2_o,
    output logic                         instr_rvalid_2_o,
    output logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_2_o,
    output logic                         mem_req_o,
    output logic [OBI_ADDR_WIDTH-1:0]    mem_addr_o,
    input  logic                         mem_gnt_i,
    input  logic                         mem_rvalid_i,
    input  logic [INSTR_RDATA_WIDTH-1:0] mem_rdata_i,
    output logic [OutW-1:0]              outstanding_o,
    output logic                         err_o
);

    core_sel_e sel;
    core_sel_e last_q, last_d;
    core_sel_e lock_sel_q, lock_sel_d;
    core_sel_e head;
    logic      lock_q, lock_d;
    logic      err_q, err_d;
    logic      sel_req;
    logic      handshake;
    logic      fifo_full, fifo_empty;
    logic      resp_valid;

    s2qed_route_fifo #(
        .Depth(MAX_OUTSTANDING)
    ) u_route_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (handshake),
        .push_sel(sel),
        .pop     (mem_rvalid_i),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (outstanding_o)
    );

    always_comb begin
        sel = CORE1;
        if (lock_q) begin
            sel = lock_sel_q;
        end else if (instr_req_1_i && instr_req_2_i) begin
            sel = other_core(last_q);
        end else if (instr_req_2_i) begin
            sel = CORE2;
        end
    end

    assign sel_req = (sel == CORE1) ? instr_req_1_i : instr_req_2_i;

    // Gated by rst_ni so every output drops the moment reset is asserted.
    assign mem_req_o  = rst_ni & sel_req & ~fifo_full;
    assign mem_addr_o = !mem_req_o   ? '0 :
                        (sel == CORE1) ? instr_addr_1_i : instr_addr_2_i;
    assign handshake  = mem_req_o & mem_gnt_i;

    assign instr_gnt_1_o = handshake & (sel == CORE1);
    assign instr_gnt_2_o = handshake & (sel == CORE2);

    assign resp_valid       = rst_ni & mem_rvalid_i & ~fifo_empty;
    assign instr_rvalid_1_o = resp_valid & (head == CORE1);
    assign instr_rvalid_2_o = resp_valid & (head == CORE2);
    assign instr_rdata_1_o  = (rst_ni && head == CORE1) ? mem_rdata_i : '0;
    assign instr_rdata_2_o  = (rst_ni && head == CORE2) ? mem_rdata_i : '0;

    assign err_o = err_q;

    always_comb begin
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        last_d     = last_q;
        err_d      = err_q;
        if (handshake) begin
            lock_d = 1'b0;
            last_d = sel;
        end else if (mem_req_o) begin
            lock_d     = 1'b1;
            lock_sel_d = sel;
        end else if (lock_q && !sel_req) begin
            // Locked core withdrew its request before being granted.
            lock_d = 1'b0;
            err_d  = 1'b1;
        end
        if (mem_rvalid_i && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_sel_q <= CORE1;
            last_q     <= CORE2;
            err_q      <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            last_q     <= last_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_s2qed_instr_fetch_bridge.sv
// Directed bench for the dual-core fetch bridge with hand-computed expectations.
module tb_s2qed_instr_fetch_bridge;

    logic        clk;
    logic        rst_n;
    logic        req1, req2;
    logic [31:0] addr1, addr2;
    logic        gnt1, gnt2, rvalid1, rvalid2;
    logic [31:0] rdata1, rdata2;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  outstanding;
    logic        err;

    int n_checks;
    int n_errors;

    s2qed_instr_fetch_bridge #(
        .INSTR_RDATA_WIDTH(32),
        .MAX_OUTSTANDING  (2)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .instr_req_1_i   (req1),
        .instr_addr_1_i  (addr1),
        .instr_gnt_1_o   (gnt1),
        .instr_rvalid_1_o(rvalid1),
        .instr_rdata_1_o (rdata1),
        .instr_req_2_i   (req2),
        .instr_addr_2_i  (addr2),
        .instr_gnt_2_o   (gnt2),
        .instr_rvalid_2_o(rvalid2),
        .instr_rdata_2_o (rdata2),
        .mem_req_o       (mem_req),
        .mem_addr_o      (mem_addr),
        .mem_gnt_i       (mem_gnt),
        .mem_rvalid_i    (mem_rvalid),
        .mem_rdata_i     (mem_rdata),
        .outstanding_o   (outstanding),
        .err_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs (called just after a falling edge) and let them settle.
    task automatic drive(input logic r1, input logic [31:0] a1, input logic r2,
                         input logic [31:0] a2, input logic g, input logic rv,
                         input logic [31:0] rd);
        req1 = r1; addr1 = a1; req2 = r2; addr2 = a2;
        mem_gnt = g; mem_rvalid = rv; mem_rdata = rd;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        idle();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        idle();
        @(negedge clk);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_outstanding", outstanding, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_gnt1", gnt1, 0);
        rst_n = 1'b1;
        step();

        // Core 1 alone.
        drive(1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check_eq("solo_gnt1", gnt1, 1);
        check_eq("solo_addr", mem_addr, 32'h80);
        check_eq("solo_gnt2", gnt2, 0);
        step();
        idle();
        check_eq("solo_out1", outstanding, 1);
        check_eq("solo_req_off", mem_req, 0);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13);
        check_eq("solo_rv1", rvalid1, 1);
        check_eq("solo_rd1", rdata1, 32'h13);
        check_eq("solo_rv2", rvalid2, 0);
        check_eq("solo_rd2", rdata2, 0);
        step();
        idle();
        check_eq("solo_out0", outstanding, 0);
        step();

        // Lock: last grant went to core 1, so core 2 would win a tie if unlocked.
        drive(1'b1, 32'h100, 1'b0, 32'h200, 1'b0, 1'b0, 32'h0);
        check_eq("lock_c0_req", mem_req, 1);
        check_eq("lock_c0_addr", mem_addr, 32'h100);
        check_eq("lock_c0_gnt1", gnt1, 0);
        step();
        for (int c = 1; c < 3; c++) begin
            drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
            check_eq("lock_hold_addr", mem_addr, 32'h100);
            check_eq("lock_hold_gnt2", gnt2, 0);
            step();
        end
        drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
        check_eq("lock_c3_gnt1", gnt1, 1);
        check_eq("lock_c3_gnt2", gnt2, 0);
        check_eq("lock_c3_addr", mem_addr, 32'h100);
        step();
        drive(1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
        check_eq("lock_c4_gnt2", gnt2, 1);
        check_eq("lock_c4_addr", mem_addr, 32'h200);
        check_eq("lock_c4_out", outstanding, 1);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h11);
        check_eq("lock_r1_rv1", rvalid1, 1);
        check_eq("lock_r1_rd1", rdata1, 32'h11);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h22);
        check_eq("lock_r2_rv2", rvalid2, 1);
        check_eq("lock_r2_rd2", rdata2, 32'h22);
        check_eq("lock_r2_rv1", rvalid1, 0);
        step();
        idle();
        check_eq("lock_done_out", outstanding, 0);
        check_eq("lock_done_err", err, 0);
        step();

        // Round-robin with fill to MAX_OUTSTANDING and in-order routing.
        pulse_reset();
        drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
        check_eq("rr_c0_gnt1", gnt1, 1);
        check_eq("rr_c0_addr", mem_addr, 32'h100);
        step();
        drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
        check_eq("rr_c1_gnt2", gnt2, 1);
        check_eq("rr_c1_addr", mem_addr, 32'h200);
        step();
        drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'hA);
        check_eq("rr_full_out", outstanding, 2);
        check_eq("rr_full_req", mem_req, 0);
        check_eq("rr_full_gnt1", gnt1, 0);
        check_eq("rr_A_rv1", rvalid1, 1);
        check_eq("rr_A_rd1", rdata1, 32'hA);
        check_eq("rr_A_rd2", rdata2, 0);
        step();
        drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'hB);
        check_eq("rr_c3_gnt1", gnt1, 1);
        check_eq("rr_B_rv2", rvalid2, 1);
        check_eq("rr_B_rd2", rdata2, 32'hB);
        step();
        drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'hC);
        check_eq("rr_c4_gnt2", gnt2, 1);
        check_eq("rr_c4_out", outstanding, 1);
        check_eq("rr_C_rv1", rvalid1, 1);
        check_eq("rr_C_rd1", rdata1, 32'hC);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hD);
        check_eq("rr_D_rv2", rvalid2, 1);
        check_eq("rr_D_rd2", rdata2, 32'hD);
        step();
        idle();
        check_eq("rr_done_out", outstanding, 0);
        step();

        // Response with empty FIFO.
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h55);
        check_eq("spur_rv1", rvalid1, 0);
        check_eq("spur_rv2", rvalid2, 0);
        check_eq("spur_err_now", err, 0);
        step();
        idle();
        check_eq("spur_err_next", err, 1);
        step();
        check_eq("spur_err_sticky", err, 1);
        pulse_reset();
        check_eq("spur_err_cleared", err, 0);

        // Locked core withdraws its request.
        drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_eq("wd_c0_addr", mem_addr, 32'h300);
        step();
        idle();
        check_eq("wd_c1_err", err, 0);
        check_eq("wd_c1_req", mem_req, 0);
        step();
        drive(1'b0, 32'h0, 1'b1, 32'h400, 1'b1, 1'b0, 32'h0);
        check_eq("wd_c2_err", err, 1);
        check_eq("wd_c2_gnt2", gnt2, 1);
        check_eq("wd_c2_addr", mem_addr, 32'h400);
        step();

        // Reset with two outstanding.
        drive(1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 1'b0, 32'h0);
        check_eq("mr_c0_gnt1", gnt1, 1);
        step();
        drive(1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 1'b0, 32'h0);
        check_eq("mr_full_out", outstanding, 2);
        check_eq("mr_full_req", mem_req, 0);
        rst_n = 1'b0;
        #1;
        check_eq("mr_rst_req", mem_req, 0);
        check_eq("mr_rst_addr", mem_addr, 0);
        check_eq("mr_rst_out", outstanding, 0);
        check_eq("mr_rst_err", err, 0);
        check_eq("mr_rst_gnt", {gnt1, gnt2}, 0);
        step();
        rst_n = 1'b1;
        #1;
        check_eq("mr_rel_gnt1", gnt1, 1);
        check_eq("mr_rel_gnt2", gnt2, 0);
        check_eq("mr_rel_addr", mem_addr, 32'h500);
        step();
        drive(1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 1'b0, 32'h0);
        check_eq("mr_next_gnt2", gnt2, 1);
        step();
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/s2qed_instr_fetch_bridge.md
Name: s2qed_instr_fetch_bridge

Overview:
- Upstream instruction-fetch stage for the dual-core S²QED harness.
- Merges the two cores' OBI-style instruction request channels (req/addr -> gnt, rvalid/rdata) onto one shared instruction-memory port. Both cores therefore fetch from an identical program image.
- Each response is routed back in order to the core that issued the request.
- Arbitration is round-robin with a lock while a request is pending, so neither core starves and address stability is preserved.

Parameters:
- INSTR_RDATA_WIDTH, 32, width of instruction read data.
- MAX_OUTSTANDING, 2, route-FIFO depth; maximum granted-but-unanswered memory transactions (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- instr_req_1_i  in  1  core 1 fetch request.
- instr_addr_1_i  in  32  core 1 fetch address.
- instr_gnt_1_o  out  1  core 1 grant.
- instr_rvalid_1_o  out  1  core 1 response valid.
- instr_rdata_1_o  out  INSTR_RDATA_WIDTH  core 1 response data.
- instr_req_2_i / instr_addr_2_i / instr_gnt_2_o / instr_rvalid_2_o / instr_rdata_2_o: same as core 1, for core 2.
- mem_req_o  out  1  shared memory request.
- mem_addr_o  out  32  shared memory address.
- mem_gnt_i  in  1  memory grant.
- mem_rvalid_i  in  1  memory response valid, in order, at least 1 cycle after gnt.
- mem_rdata_i  in  INSTR_RDATA_WIDTH  memory response data.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current route-FIFO occupancy.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset values (rst_ni low): all outputs 0; FIFO empty; lock_q=0; last_q=CORE2, so core 1 wins the first tie.
- Arbitration (combinational):
  - If lock_q=1, sel = lock_sel_q.
  - Otherwise: only one req high -> that core; both high -> the core != last_q.
- mem_req_o = (selected req) & !full. mem_addr_o = selected core's address. Address is 0 when mem_req_o=0.
- instr_gnt_k_o = mem_gnt_i & mem_req_o & (sel==k). The grant is combinational pass-through, zero added latency. The non-selected core's gnt is 0.
- Lock:
  - mem_req_o=1 & mem_gnt_i=0: next lock_q=1, lock_sel_q=sel.
  - Handshake (mem_req_o & mem_gnt_i): next lock_q=0, last_q=sel.
  - Purpose: the address/core stays stable until granted (OBI rule). The other core's request cannot pre-empt.
- Full:
  - When FIFO occupancy == MAX_OUTSTANDING, mem_req_o=0 and no gnt is given.
  - A pop in the same cycle does not free a slot until the next cycle (no bypass).
  - Lock state is retained while full.
- Route FIFO:
  - Push sel on handshake.
  - Pop on mem_rvalid_i.
  - Push and pop in the same cycle (not full): occupancy unchanged.
- Response:
  - instr_rvalid_k_o = mem_rvalid_i & !empty & (head==k).
  - instr_rdata_k_o = mem_rdata_i when head==k, else 0.
  - Zero added latency.
- Error:
  - mem_rvalid_i while FIFO empty: err_o is set next cycle and stays set until reset; the response is dropped and no rvalid is issued.
  - A core deasserting req while locked and ungranted also sets err_o; lock_q is cleared.
- Reset mid-operation: FIFO and lock are flushed immediately. Late responses after reset hit the empty-FIFO error rule.

Decomposition:
- Package s2qed_fetch_pkg:
  - typedef enum logic {CORE1=1'b0, CORE2=1'b1} core_sel_e.
  - Constant OBI_ADDR_WIDTH=32.
- Sub-module s2qed_route_fifo: parameterised depth, 1-bit core_sel_e entries, push/pop/full/empty/count, async active-low reset.

Test Plan:
- Core 1 alone, addr 0x0000_0080, mem_gnt_i=1 same cycle, rvalid 2 cycles later with 0x0000_0013 -> instr_gnt_1_o=1 in cycle 0; instr_rvalid_1_o=1 with rdata 0x13 in cycle 2; core 2 sees nothing.
- Both cores request continuously (0x100 vs 0x200), gnt always 1 -> grants alternate 1,2,1,2; responses 0xA,0xB,0xC,0xD route to cores 1,2,1,2 respectively.
- Core 1 requests 0x100 with mem_gnt_i=0 for 3 cycles while core 2 raises req at cycle 1 -> mem_addr_o holds 0x100 all 3 cycles; core 1 granted at cycle 3; core 2 granted next.
- MAX_OUTSTANDING=2, gnt always 1, no rvalid -> two grants, then mem_req_o=0 and outstanding_o=2. One rvalid -> next cycle a new grant is possible.
- mem_rvalid_i pulse with empty FIFO -> no instr_rvalid; err_o=1 next cycle and stays 1 until rst_ni low.
- rst_ni asserted with 2 outstanding -> outputs 0 immediately, outstanding_o=0; after release, core 1 wins the first tie.
